piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock on a single serial line, qualified by a frame strobe. An optional even-parity bit follows the data. The block generates serial `d` streams for our flip-flop and shift-register blocks, so it is the driving end of that serial bit interface.

Parameters:
WIDTH, 8, number of data bits per word (legal values 2..32)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
PARITY_EN, 0, 1 = append one even-parity bit after the data bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  word to transmit; sampled only on an accepted load
load_valid  input  1  producer has a word on data_in
load_ready  output  1  block can accept a word this cycle
d_out  output  1  serial data bit (registered)
frame  output  1  d_out carries a valid bit this cycle (registered)
last  output  1  current bit is the final bit of the frame (registered)

Behaviour:
- Reset is asynchronous and active-high. While reset=1, or immediately after it asserts:
  - state=IDLE, shift register=0, bit counter=0
  - d_out=0, frame=0, last=0, load_ready=1
  - load_valid is ignored while reset=1.
- Accept: a load is accepted on a rising edge where load_valid=1, load_ready=1 and reset=0. That edge captures data_in.
- States:
  - IDLE: frame=0, d_out=0, load_ready=1. An accepted load moves to SHIFT.
  - SHIFT: one data bit per cycle for WIDTH cycles. frame=1 and load_ready=0, except on the last data bit when PARITY_EN=0.
    - After the last data bit: go to PARITY if PARITY_EN=1; otherwise go to IDLE, or restart SHIFT if a load was accepted on that edge.
  - PARITY (only when PARITY_EN=1): one cycle. d_out = XOR of all captured bits, so data plus parity has an even count of ones. frame=1, last=1, load_ready=1. Next state is IDLE, or SHIFT on an accepted load.
- Latency: the load accepted at edge N puts its first bit on d_out at edge N (visible during cycle N..N+1). Bit k appears at edge N+k. Frame length is WIDTH cycles, or WIDTH+1 with parity.
- Bit order: MSB_FIRST=1 sends data_in[WIDTH-1] down to data_in[0]. MSB_FIRST=0 sends data_in[0] up to data_in[WIDTH-1].
- last=1 only on the final bit of the frame: the last data bit when PARITY_EN=0, the parity bit otherwise.
- load_ready is high in IDLE and on the final bit cycle. This permits back-to-back frames with zero gap: frame stays 1 continuously and last pulses once per word.
- load_valid while load_ready=0 is ignored. No word is captured, and the in-flight frame is unaffected.
- data_in changing mid-frame has no effect, because the word is captured at acceptance.
- Bit counter: width $clog2(WIDTH+1). It wraps to 0 at the end of every frame.
- Reset mid-frame aborts the frame immediately: frame=0, last=0. No further bits of that word are sent after reset deasserts.
- When frame=0, d_out is held at 0.

Test Plan:
1. Reset, then hold: reset=1 for 12 time units with load_valid=1 -> d_out=0, frame=0, last=0, load_ready=1 throughout; no frame starts. After release, load_valid=0 -> state remains IDLE.
2. Single word: WIDTH=8, MSB_FIRST=1, PARITY_EN=0, load 8'hA5 -> d_out = 1,0,1,0,0,1,0,1 on 8 consecutive edges. frame=1 for exactly 8 cycles; last=1 only on the 8th bit; load_ready=0 for bits 1..7.
3. Back-to-back: load 8'hA5, then hold load_valid=1 with data_in=8'h3C -> 3C is accepted on the last-bit edge. d_out continues with 0,0,1,1,1,1,0,0; frame stays 1 for 16 cycles; last pulses twice.
4. Parity and LSB-first: MSB_FIRST=0, PARITY_EN=1. Load 8'h01 -> 1,0,0,0,0,0,0,0 then parity 1, 9-cycle frame. Load 8'hA5 -> 1,0,1,0,0,1,0,1 then parity 0.
5. Reset mid-frame: assert reset after the 3rd bit of 8'hFF -> frame and d_out drop to 0 asynchronously, before the next clock edge. After release, a new load of 8'h0F sends 0,0,0,0,1,1,1,1 cleanly.
6. Busy load ignored: during a frame of 8'hA5, pulse load_valid with 8'hFF while load_ready=0 -> the A5 stream is unchanged and no extra frame follows.

Source files
------------

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in/serial-out transmitter. Takes a WIDTH-bit word
//               over valid/ready and sends it one bit per clock on d_out,
//               qualified by frame/last. An even-parity bit may follow.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             frame,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);
  // Index of the final data bit, and of the one just before it.
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_pen  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // State describes the bit currently presented on d_out.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             d_out_q, d_out_d;
  logic             frame_q, frame_d;
  logic             last_q, last_d;

  logic             w_accept;
  logic             w_start;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  // Ready in IDLE and on the final bit of a frame, allowing zero-gap frames.
  assign load_ready = (state_q == IDLE) | last_q;
  assign w_accept   = load_valid & load_ready;
  assign w_next_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign w_shifted  = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

  assign d_out = d_out_q;
  assign frame = frame_q;
  assign last  = last_q;

  // Next-state and next-output logic; the first bit of a word is emitted on
  // the same edge that accepts it.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    d_out_d = 1'b0;
    frame_d = 1'b0;
    last_d  = 1'b0;
    w_start = 1'b0;

    case (state_q)
      IDLE: begin
        w_start = w_accept;
      end
      SHIFT: begin
        if (cnt_q != c_last) begin
          d_out_d = w_next_bit;
          shreg_d = w_shifted;
          cnt_d   = cnt_q + 1'b1;
          frame_d = 1'b1;
          last_d  = (cnt_q == c_pen) && (PARITY_EN == 0);
        end else begin
          cnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d = PARITY;
            d_out_d = par_q;
            frame_d = 1'b1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
            w_start = w_accept;
          end
        end
      end
      PARITY: begin
        cnt_d   = '0;
        state_d = IDLE;
        w_start = w_accept;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Capture the word and put its first bit out immediately.
    if (w_start) begin
      state_d = SHIFT;
      cnt_d   = '0;
      par_d   = ^data_in;
      frame_d = 1'b1;
      last_d  = 1'b0;
      if (MSB_FIRST != 0) begin
        d_out_d = data_in[WIDTH-1];
        shreg_d = data_in << 1;
      end else begin
        d_out_d = data_in[0];
        shreg_d = data_in >> 1;
      end
    end
  end

  // State and output registers; reset aborts any frame at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      d_out_q <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      d_out_q <= d_out_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Directed self-checking bench for piso_tx. Instance a uses
//               MSB-first without parity, instance b LSB-first with parity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_a = '0, data_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, d_a, frame_a, last_a;
  logic       ready_b, d_b, frame_b, last_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_a), .load_valid(valid_a),
    .load_ready(ready_a), .d_out(d_a), .frame(frame_a), .last(last_a));

  piso_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_b), .load_valid(valid_b),
    .load_ready(ready_b), .d_out(d_b), .frame(frame_b), .last(last_b));

  // Status vectors are {d_out, frame, last, load_ready}.
  task automatic test_reset();
    logic [3:0] obs;
    valid_a = 1'b1; data_a = 8'hFF;
    valid_b = 1'b1; data_b = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #3;
      obs = {d_a, frame_a, last_a, ready_a};
      if (obs !== 4'b0001) begin
        n_err++; $display("FAIL reset_hold_a[%0d] got %b want 0001", i, obs);
      end
      n_cmp++;
      obs = {d_b, frame_b, last_b, ready_b};
      if (obs !== 4'b0001) begin
        n_err++; $display("FAIL reset_hold_b[%0d] got %b want 0001", i, obs);
      end
      n_cmp++;
    end
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      obs = {d_a, frame_a, last_a, ready_a};
      if (obs !== 4'b0001) begin
        n_err++; $display("FAIL reset_idle[%0d] got %b want 0001", i, obs);
      end
      n_cmp++;
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic [3:0] obs, exp;
    w = 8'hA5;
    @(negedge clk); valid_a = 1'b1; data_a = w;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) valid_a = 1'b0;
      exp = {w[7-k], 1'b1, (k == 7), (k == 7)};
      obs = {d_a, frame_a, last_a, ready_a};
      if (obs !== exp) begin
        n_err++; $display("FAIL single_bit[%0d] got %b want %b", k, obs, exp);
      end
      n_cmp++;
    end
    @(posedge clk); #1;
    obs = {d_a, frame_a, last_a, ready_a};
    if (obs !== 4'b0001) begin
      n_err++; $display("FAIL single_end got %b want 0001", obs);
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic [3:0]  obs, exp;
    w = 16'hA53C;
    @(negedge clk); valid_a = 1'b1; data_a = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (k == 0) data_a = 8'h3C;
      if (k == 8) valid_a = 1'b0;
      exp = {w[15-k], 1'b1, (k == 7 || k == 15), (k == 7 || k == 15)};
      obs = {d_a, frame_a, last_a, ready_a};
      if (obs !== exp) begin
        n_err++; $display("FAIL b2b_bit[%0d] got %b want %b", k, obs, exp);
      end
      n_cmp++;
    end
    @(posedge clk); #1;
    obs = {d_a, frame_a, last_a, ready_a};
    if (obs !== 4'b0001) begin
      n_err++; $display("FAIL b2b_end got %b want 0001", obs);
    end
    n_cmp++;
  endtask

  task automatic test_parity_lsb();
    logic [7:0] words [2];
    logic       pars  [2];
    logic [7:0] w;
    logic [3:0] obs, exp;
    words[0] = 8'h01; pars[0] = 1'b1;
    words[1] = 8'hA5; pars[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      w = words[n];
      @(negedge clk); valid_b = 1'b1; data_b = w;
      for (int k = 0; k < 9; k++) begin
        @(posedge clk); #1;
        if (k == 0) valid_b = 1'b0;
        if (k < 8) exp = {w[k], 1'b1, 1'b0, 1'b0};
        else       exp = {pars[n], 1'b1, 1'b1, 1'b1};
        obs = {d_b, frame_b, last_b, ready_b};
        if (obs !== exp) begin
          n_err++;
          $display("FAIL parity_w%0d_bit[%0d] got %b want %b", n, k, obs, exp);
        end
        n_cmp++;
      end
      @(posedge clk); #1;
      obs = {d_b, frame_b, last_b, ready_b};
      if (obs !== 4'b0001) begin
        n_err++; $display("FAIL parity_w%0d_end got %b want 0001", n, obs);
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    logic [3:0] obs, exp;
    @(negedge clk); valid_a = 1'b1; data_a = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) valid_a = 1'b0;
    end
    obs = {d_a, frame_a, last_a, ready_a};
    if (obs !== 4'b1100) begin
      n_err++; $display("FAIL midrst_pre got %b want 1100", obs);
    end
    n_cmp++;
    #2 reset = 1'b1;
    #1;
    obs = {d_a, frame_a, last_a, ready_a};
    if (obs !== 4'b0001) begin
      n_err++; $display("FAIL midrst_async got %b want 0001", obs);
    end
    n_cmp++;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      obs = {d_a, frame_a, last_a, ready_a};
      if (obs !== 4'b0001) begin
        n_err++; $display("FAIL midrst_idle[%0d] got %b want 0001", i, obs);
      end
      n_cmp++;
    end
    w = 8'h0F;
    @(negedge clk); valid_a = 1'b1; data_a = w;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) valid_a = 1'b0;
      exp = {w[7-k], 1'b1, (k == 7), (k == 7)};
      obs = {d_a, frame_a, last_a, ready_a};
      if (obs !== exp) begin
        n_err++; $display("FAIL midrst_reload_bit[%0d] got %b want %b", k, obs, exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_busy_ignored();
    logic [7:0] w;
    logic [3:0] obs, exp;
    w = 8'hA5;
    @(negedge clk); valid_a = 1'b1; data_a = w;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 0) valid_a = 1'b0;
      if (k == 2) begin valid_a = 1'b1; data_a = 8'hFF; end
      if (k == 3) valid_a = 1'b0;
      exp = {w[7-k], 1'b1, (k == 7), (k == 7)};
      obs = {d_a, frame_a, last_a, ready_a};
      if (obs !== exp) begin
        n_err++; $display("FAIL busy_bit[%0d] got %b want %b", k, obs, exp);
      end
      n_cmp++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      obs = {d_a, frame_a, last_a, ready_a};
      if (obs !== 4'b0001) begin
        n_err++; $display("FAIL busy_no_extra[%0d] got %b want 0001", i, obs);
      end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_lsb();
    test_reset_mid_frame();
    test_busy_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
